// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver: hex glyphs, off pattern, FSM states.
package seg_pkg;

  // Active-high {g,f,e,d,c,b,a} glyphs for hex digits 0-F
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  // Active-low {dp,g..a} pattern with every segment dark
  localparam logic [7:0] SEG_OFF = 8'hFF;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-high 7-segment glyph decoder.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg_c
);

  // Glyph lookup, lowercase b/d forms for 0xB/0xD
  always_comb begin
    seg_c = SEG_0;
    case (nib)
      4'h0: seg_c = SEG_0;
      4'h1: seg_c = SEG_1;
      4'h2: seg_c = SEG_2;
      4'h3: seg_c = SEG_3;
      4'h4: seg_c = SEG_4;
      4'h5: seg_c = SEG_5;
      4'h6: seg_c = SEG_6;
      4'h7: seg_c = SEG_7;
      4'h8: seg_c = SEG_8;
      4'h9: seg_c = SEG_9;
      4'hA: seg_c = SEG_A;
      4'hB: seg_c = SEG_B;
      4'hC: seg_c = SEG_C;
      4'hD: seg_c = SEG_D;
      4'hE: seg_c = SEG_E;
      4'hF: seg_c = SEG_F;
      default: seg_c = SEG_0;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed multi-digit 7-segment scan driver with per-slot ghost interval.
// Optional leading-zero blanking when SEG_SCAN_LZB_EN is defined.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned GHOST_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  output logic [7:0]            seg_n,
  output logic [DIGITS-1:0]     sel_n,
  output logic                  frame_tick
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [4*DIGITS-1:0]   nib_snap;
  logic [DIGITS-1:0]     dp_snap;
  logic [DIGITS-1:0]     blank_snap;
  logic [DIGITS-1:0]     lzb_mask;
  logic                  snap_c;
  logic [3:0]            nib_cur;
  logic [6:0]            glyph_c;
  logic [7:0]            seg_d;
  logic [DIGITS-1:0]     sel_d;

  // Snapshot point: first cycle of the digit-0 slot while enabled
  assign snap_c = en && (cnt == '0) && (idx == '0);

`ifdef SEG_SCAN_LZB_EN
  logic lead;

  // Blank leading zero digits (no dp) from the top; digit 0 always shown
  always_comb begin
    lzb_mask = '0;
    lead     = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      if (lead && (digits_in[4*i +: 4] == 4'h0) && !dp_in[i]) begin
        lzb_mask[i] = 1'b1;
      end else begin
        lead = 1'b0;
      end
    end
  end
`else
  assign lzb_mask = '0;
`endif

  // Frame snapshot registers so mid-frame input changes never tear
  always_ff @(posedge clk) begin
    if (rst) begin
      nib_snap   <= '0;
      dp_snap    <= '0;
      blank_snap <= '0;
    end else if (snap_c) begin
      nib_snap   <= digits_in;
      dp_snap    <= dp_in;
      blank_snap <= blank_in | lzb_mask;
    end
  end

  assign nib_cur = nib_snap[4*idx +: 4];

  hex_to_seg u_hex_to_seg (
    .nib   (nib_cur),
    .seg_c (glyph_c)
  );

  // FSM state, slot counter and digit index registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state, slot advance and pre-register output values
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    sel_d     = '1;
    seg_d     = SEG_OFF;

    if (!en) begin
      state_nxt = ST_BLANK;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else begin
      if (cnt == CNT_W'(TICK_DIV - 1)) begin
        cnt_nxt = '0;
        idx_nxt = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end

      case (state)
        ST_BLANK: begin
          if (cnt == CNT_W'(GHOST_CYCLES - 1)) state_nxt = ST_DRIVE;
        end
        ST_DRIVE: begin
          if (cnt == CNT_W'(TICK_DIV - 1)) state_nxt = ST_BLANK;
          if (!blank_snap[idx]) begin
            sel_d = ~(DIGITS'(1) << idx);
            seg_d = ~{dp_snap[idx], glyph_c};
          end
        end
        default: state_nxt = ST_BLANK;
      endcase
    end
  end

  // Registered display outputs and frame pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_n      <= '1;
      seg_n      <= SEG_OFF;
      frame_tick <= 1'b0;
    end else begin
      sel_n      <= sel_d;
      seg_n      <= seg_d;
      frame_tick <= snap_c;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (DIGITS=4, TICK_DIV=8, GHOST_CYCLES=2).
// Honours SEG_SCAN_LZB_EN the same way as the design.
module tb_seg_scan_driver;

  localparam int D = 4;
  localparam int T = 8;
  localparam int G = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [15:0]  digits_in;
  logic [3:0]   dp_in;
  logic [3:0]   blank_in;
  logic [7:0]   seg_n;
  logic [3:0]   sel_n;
  logic         frame_tick;

  int checks = 0;
  int errors = 0;

  // Reference model state: enabled-cycle count since restart plus frame snapshot
  int          t = 0;
  logic [3:0]  m_nib [D];
  logic [D-1:0] m_dp;
  logic [D-1:0] m_blank;
  logic [3:0]  e_sel;
  logic [7:0]  e_seg;
  logic        e_ft;

  seg_scan_driver #(
    .DIGITS       (D),
    .TICK_DIV     (T),
    .GHOST_CYCLES (G)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .seg_n      (seg_n),
    .sel_n      (sel_n),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return tbl[n];
  endfunction

  // Advance the model by one clock using the inputs the DUT is about to sample
  task automatic model_step();
    int phase, slot, c;
    bit lead;
    e_sel = 4'hF;
    e_seg = 8'hFF;
    e_ft  = 1'b0;
    if (rst) begin
      t = 0;
      for (int i = 0; i < D; i++) m_nib[i] = 4'h0;
      m_dp    = '0;
      m_blank = '0;
    end else if (!en) begin
      t = 0;
    end else begin
      phase = t % (T * D);
      slot  = phase / T;
      c     = phase % T;
      if (phase == 0) begin
        e_ft = 1'b1;
        for (int i = 0; i < D; i++) m_nib[i] = digits_in[4*i +: 4];
        m_dp    = dp_in;
        m_blank = blank_in;
`ifdef SEG_SCAN_LZB_EN
        lead = 1'b1;
        for (int i = D - 1; i >= 1; i--) begin
          if (lead && m_nib[i] == 4'h0 && !m_dp[i]) m_blank[i] = 1'b1;
          else lead = 1'b0;
        end
`endif
      end
      if (c >= G && !m_blank[slot]) begin
        e_sel[slot] = 1'b0;
        e_seg = {~m_dp[slot], ~glyph(m_nib[slot])};
      end
      t++;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0t observed %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      model_step();
      @(posedge clk);
      #1;
      chk("sel_n", {4'h0, sel_n}, {4'h0, e_sel});
      chk("seg_n", seg_n, e_seg);
      chk("frame_tick", {7'h0, frame_tick}, {7'h0, e_ft});
    end
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b1;
    digits_in = 16'h1234;
    dp_in     = 4'h0;
    blank_in  = 4'h0;

    // Reset, then release and scan two full frames of 1234
    ticks(2);
    rst = 1'b0;
    ticks(2 * T * D);

    // Change input during digit 1 slot; must not tear the current frame
    ticks(T + 3);
    digits_in = 16'hFFFF;
    ticks(2 * T * D);

    // Leading zeros
    digits_in = 16'h0042;
    ticks(2 * T * D);

    // Decimal point and forced blanking
    dp_in    = 4'b0010;
    blank_in = 4'b0100;
    ticks(2 * T * D);

    // Drop enable mid-DRIVE, then restart
    dp_in    = 4'h0;
    blank_in = 4'h0;
    digits_in = 16'hA5C0;
    ticks(T + G + 2);
    en = 1'b0;
    ticks(5);
    en = 1'b1;
    ticks(2 * T * D);

    // Reset mid-scan aborts the slot
    ticks(13);
    rst = 1'b1;
    ticks(1);
    rst = 1'b0;
    ticks(T * D);

    // Randomized inputs, enable drops and occasional reset
    for (int r = 0; r < 80; r++) begin
      digits_in = 16'($urandom);
      if ($urandom_range(0, 2) == 0) digits_in[15:8] = 8'h00;
      dp_in    = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      en       = ($urandom_range(0, 7) != 0);
      rst      = ($urandom_range(0, 19) == 0);
      ticks(1);
      rst = 1'b0;
      ticks($urandom_range(1, 45));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
